mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 14 +
 rtl/lsu_load_align.sv | 19 +
 rtl/mem_lsu.sv | 99 +++++++++
 tb/tb_mem_lsu.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared FSM state encodings, funct3 size codes and data width for the load/store unit
package mem_lsu_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the loaded byte/half lane from a bus word and sign/zero-extends it
// Ports: i_funct3 load size/sign, i_lo byte offset within the word, i_rdata bus word, o_data extended result.
module lsu_load_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_lo,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data
);
  logic [15:0] w_h;
  logic [7:0]  w_b;
  assign w_h = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_b = i_lo[0] ? w_h[15:8] : w_h[7:0];
  assign o_data = i_funct3 == F3_B  ? {{24{w_b[7]}}, w_b} :
                  i_funct3 == F3_BU ? {24'h0, w_b} :
                  i_funct3 == F3_H  ? {{16{w_h[15]}}, w_h} :
                  i_funct3 == F3_HU ? {16'h0, w_h} : i_rdata;
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit bridging the memory stage to a req/gnt/rvalid bus
// Ports: clk, rst_n (async, active-low); valid_M, mem_rd_M, mem_wr_M, funct3_M, ALU_result_M, rs2_data_M
//        from the memory stage; bus_req/we/addr/wdata/wstrb out, bus_gnt/rvalid/rdata in;
//        Rdata_W (load result), stall_M (hold upstream), misalign_err out.
// Macro LSU_MISALIGN_TRAP_EN: reject misaligned half/word accesses with a misalign_err pulse
// instead of forcing them to natural alignment.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_M,
  input  logic            mem_rd_M,
  input  logic            mem_wr_M,
  input  logic [2:0]      funct3_M,
  input  logic [XLEN-1:0] ALU_result_M,
  input  logic [XLEN-1:0] rs2_data_M,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_wstrb,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  output logic [XLEN-1:0] Rdata_W,
  output logic            stall_M,
  output logic            misalign_err
);
  state_t          r_state;
  logic [2:0]      r_f3;
  logic [1:0]      r_lo;
  logic [1:0]      w_lo;
  logic            w_is_b, w_is_h, w_go, w_acc;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata, w_ld;
  assign w_is_b = funct3_M == F3_B || funct3_M == F3_BU;
  assign w_is_h = funct3_M == F3_H || funct3_M == F3_HU;
  // Offset forced to natural alignment; undefined funct3 behaves as a word access
  assign w_lo = w_is_b ? ALU_result_M[1:0] : w_is_h ? {ALU_result_M[1], 1'b0} : 2'b00;
  assign w_go = r_state == S_IDLE && valid_M && (mem_rd_M || mem_wr_M);
`ifdef LSU_MISALIGN_TRAP_EN
  logic w_mis;
  // Misaligned exactly when forcing alignment would change the offset
  assign w_mis = w_lo != ALU_result_M[1:0];
  assign w_acc = w_go && !w_mis;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) misalign_err <= 1'b0;
    else misalign_err <= w_go && w_mis;
`else
  assign w_acc = w_go;
  assign misalign_err = 1'b0;
`endif
  assign w_wdata = w_is_b ? {4{rs2_data_M[7:0]}} : w_is_h ? {2{rs2_data_M[15:0]}} : rs2_data_M;
  assign w_wstrb = w_is_b ? 4'b0001 << w_lo : w_is_h ? 4'b0011 << w_lo : 4'b1111;
  // Combinational so the completing cycle releases the pipeline without an extra bubble
  assign stall_M = rst_n && (w_acc || (r_state == S_REQ && !(bus_gnt && bus_we)) ||
                             (r_state == S_WAIT && !bus_rvalid));
  lsu_load_align u_align (
    .i_funct3(r_f3),
    .i_lo    (r_lo),
    .i_rdata (bus_rdata),
    .o_data  (w_ld)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_f3      <= '0;
      r_lo      <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      Rdata_W   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_acc) begin
          r_state   <= S_REQ;
          r_f3      <= funct3_M;
          r_lo      <= w_lo;
          bus_req   <= 1'b1;
          bus_we    <= !mem_rd_M;
          bus_addr  <= {ALU_result_M[31:2], 2'b00};
          bus_wdata <= w_wdata;
          bus_wstrb <= mem_rd_M ? 4'b0000 : w_wstrb;
        end
        S_REQ: if (bus_gnt) begin
          bus_req <= 1'b0;
          r_state <= bus_we ? S_IDLE : S_WAIT;
        end
        S_WAIT: if (bus_rvalid) begin
          Rdata_W <= w_ld;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and random load/store transactions checked against a reference scoreboard
module tb_mem_lsu;
  logic        clk, rst_n, valid_M, mem_rd_M, mem_wr_M;
  logic [2:0]  funct3_M;
  logic [31:0] ALU_result_M, rs2_data_M;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, Rdata_W;
  logic [3:0]  bus_wstrb;
  logic        stall_M, misalign_err;
  int total = 0;
  int bad = 0;
  logic [31:0] last_rd;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } sb_t;
  sb_t sb[$];

  mem_lsu dut (
    .clk(clk), .rst_n(rst_n), .valid_M(valid_M), .mem_rd_M(mem_rd_M), .mem_wr_M(mem_wr_M),
    .funct3_M(funct3_M), .ALU_result_M(ALU_result_M), .rs2_data_M(rs2_data_M),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .Rdata_W(Rdata_W), .stall_M(stall_M), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic sb_t model(input logic rd, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] rdat);
    sb_t e;
    int sz;
    logic [31:0] al, v;
    sz = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    al = a & ~32'(sz - 1);
    e.we = !rd;
    e.addr = {a[31:2], 2'b00};
    for (int i = 0; i < 4; i++) begin
      e.wstrb[i] = i >= int'(al[1:0]) && i < int'(al[1:0]) + sz;
      e.wdata[8*i +: 8] = d[8*(i % sz) +: 8];
    end
    v = rdat >> (8 * al[1:0]);
    if (sz == 1) v = f3[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    if (sz == 2) v = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    e.rdata = v;
    return e;
  endfunction

  task automatic xact(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] rdat, input int gd, input int rvd);
    sb_t e;
    sb.push_back(model(rd, f3, a, d, rdat));
    valid_M = 1'b1; mem_rd_M = rd; mem_wr_M = wr; funct3_M = f3; ALU_result_M = a; rs2_data_M = d;
    #1 chk("accept_stall", 32'(stall_M), 32'd1);
    chk("accept_misalign", 32'(misalign_err), 32'd0);
    @(negedge clk);
    valid_M = 1'b0; mem_rd_M = 1'b0; mem_wr_M = 1'b0; ALU_result_M = $urandom; rs2_data_M = $urandom;
    e = sb.pop_front();
    for (int i = 0; i <= gd; i++) begin
      chk("req_bus_req", 32'(bus_req), 32'd1);
      chk("req_bus_we", 32'(bus_we), 32'(e.we));
      chk("req_bus_addr", bus_addr, e.addr);
      chk("req_stall", 32'(stall_M), 32'd1);
      if (e.we) begin
        chk("req_bus_wdata", bus_wdata, e.wdata);
        chk("req_bus_wstrb", 32'(bus_wstrb), 32'(e.wstrb));
      end
      if (i < gd) @(negedge clk);
    end
    bus_gnt = 1'b1;
    #1 chk("gnt_stall", 32'(stall_M), e.we ? 32'd0 : 32'd1);
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("post_gnt_req", 32'(bus_req), 32'd0);
    if (!e.we) begin
      for (int i = 0; i < rvd; i++) begin
        chk("wait_stall", 32'(stall_M), 32'd1);
        @(negedge clk);
        chk("wait_req", 32'(bus_req), 32'd0);
      end
      bus_rvalid = 1'b1; bus_rdata = rdat;
      #1 chk("rvalid_stall", 32'(stall_M), 32'd0);
      @(negedge clk);
      bus_rvalid = 1'b0; bus_rdata = $urandom;
      chk("load_rdata", Rdata_W, e.rdata);
      last_rd = e.rdata;
    end
  endtask

  initial begin
    logic [2:0] lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] f;
    logic [31:0] a;
    logic r;
    rst_n = 1'b0; valid_M = 1'b1; mem_rd_M = 1'b1; mem_wr_M = 1'b0; funct3_M = 3'b010;
    ALU_result_M = 32'h100; rs2_data_M = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    last_rd = 32'h0;
    @(negedge clk);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst_rdata", Rdata_W, 32'd0);
    chk("rst_stall", 32'(stall_M), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    rst_n = 1'b1; valid_M = 1'b0; mem_rd_M = 1'b0;
    @(negedge clk);
    xact(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1);
    chk("lb_0x103", Rdata_W, 32'hFFFFFF80);
    xact(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3, 0);
    xact(1, 0, 3'b101, 32'h002, 32'h0, 32'hBEEF1234, 1, 0);
    chk("lhu_0x002", Rdata_W, 32'h0000BEEF);
`ifdef LSU_MISALIGN_TRAP_EN
    valid_M = 1'b1; mem_rd_M = 1'b1; funct3_M = 3'b010; ALU_result_M = 32'h5;
    #1 chk("mis_stall", 32'(stall_M), 32'd0);
    chk("mis_req0", 32'(bus_req), 32'd0);
    @(negedge clk);
    valid_M = 1'b0; mem_rd_M = 1'b0;
    chk("mis_pulse", 32'(misalign_err), 32'd1);
    chk("mis_req1", 32'(bus_req), 32'd0);
    @(negedge clk);
    chk("mis_pulse_end", 32'(misalign_err), 32'd0);
    chk("mis_req2", 32'(bus_req), 32'd0);
    chk("mis_rdata", Rdata_W, last_rd);
`else
    xact(1, 0, 3'b010, 32'h005, 32'h0, 32'h11223344, 0, 0);
    chk("lw_0x005", Rdata_W, 32'h11223344);
    xact(1, 0, 3'b001, 32'h007, 32'h0, 32'h80017FFF, 0, 0);
`endif
    xact(1, 0, 3'b001, 32'h006, 32'h0, 32'h80017FFF, 0, 2);
    xact(1, 0, 3'b100, 32'h001, 32'h0, 32'h0000F000, 2, 0);
    xact(0, 1, 3'b000, 32'h011, 32'h000000A5, 32'h0, 0, 0);
    xact(0, 1, 3'b010, 32'h020, 32'hCAFEF00D, 32'h0, 1, 0);
    xact(1, 1, 3'b010, 32'h030, 32'h99999999, 32'h12345678, 0, 0);
    xact(1, 0, 3'b111, 32'h044, 32'h0, 32'h87654321, 0, 1);
    xact(0, 1, 3'b011, 32'h048, 32'h0BADF00D, 32'h0, 0, 0);
    for (int n = 0; n < 16; n++) begin
      r = 1'($urandom_range(0, 1));
      f = r ? lf[$urandom_range(0, 4)] : lf[$urandom_range(0, 2)];
      a = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
      a = f[1:0] == 2'b00 ? a : f[1:0] == 2'b01 ? {a[31:1], 1'b0} : {a[31:2], 2'b00};
`endif
      xact(r, !r || 1'($urandom_range(0, 1)), f, a, $urandom, $urandom,
           $urandom_range(0, 2), $urandom_range(0, 2));
    end
    xact(1, 0, 3'b010, 32'h050, 32'h0, 32'h5A5A0001, 0, 0);
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("idle_rvalid_ignored", Rdata_W, 32'h5A5A0001);
    valid_M = 1'b1; mem_rd_M = 1'b1; funct3_M = 3'b010; ALU_result_M = 32'h60;
    @(negedge clk);
    valid_M = 1'b0; mem_rd_M = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("wait_before_rst_stall", 32'(stall_M), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_req", 32'(bus_req), 32'd0);
    chk("async_rst_rdata", Rdata_W, 32'd0);
    chk("async_rst_addr", bus_addr, 32'd0);
    chk("async_rst_stall", 32'(stall_M), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
    #1 chk("late_rvalid_stall", 32'(stall_M), 32'd0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("late_rvalid_rdata", Rdata_W, 32'd0);
    chk("late_rvalid_req", 32'(bus_req), 32'd0);
    xact(1, 0, 3'b000, 32'h072, 32'h0, 32'h00330000, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
